// File: rtl/memblock_mq.sv
// rtl/memblock_mq.sv - in-order multi-outstanding load/store queue driving the tbus
// Optional feature: define LSU_MISALIGN_CHECK_EN to trap misaligned accesses instead of issuing them.
module memblock_mq #(
  parameter int XLEN   = 64,
  parameter int PREG_W = 6,
  parameter int ROB_W  = 6,
  parameter int DEPTH  = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic              in_is_unsigned,
  input  logic [3:0]        in_ls_size,
  input  logic [XLEN-1:0]   in_src1,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_src2,
  input  logic [PREG_W-1:0] in_prd,
  input  logic              in_robidx_flag,
  input  logic [ROB_W-1:0]  in_robidx,
  output logic              tbus_req_valid,
  input  logic              tbus_req_ready,
  output logic [XLEN-1:0]   tbus_req_addr,
  output logic [XLEN-1:0]   tbus_req_wdata,
  output logic [XLEN-1:0]   tbus_req_wmask,
  output logic [1:0]        tbus_req_optype,
  input  logic              tbus_resp_valid,
  input  logic [XLEN-1:0]   tbus_resp_rdata,
  input  logic              flush_valid,
  input  logic              flush_robidx_flag,
  input  logic [ROB_W-1:0]  flush_robidx,
  output logic              out_valid,
  output logic              out_need_to_wb,
  output logic              out_exception,
  output logic [PREG_W-1:0] out_prd,
  output logic              out_robidx_flag,
  output logic [ROB_W-1:0]  out_robidx,
  output logic [XLEN-1:0]   out_data,
  output logic              busy
);
  localparam int IW = $clog2(DEPTH);
  localparam int PW = IW + 1;
  localparam logic [PW-1:0] PTR_ONE = 1;

  logic [PW-1:0] alloc_ptr, issue_ptr, retire_ptr;
  logic [DEPTH-1:0] e_valid, e_killed, e_issued, e_load, e_uns, e_mis, e_flag;
  logic [3:0]        e_size  [DEPTH];
  logic [XLEN-1:0]   e_addr  [DEPTH];
  logic [XLEN-1:0]   e_wdata [DEPTH];
  logic [XLEN-1:0]   e_wmask [DEPTH];
  logic [PREG_W-1:0] e_prd   [DEPTH];
  logic [ROB_W-1:0]  e_rob   [DEPTH];

  function automatic logic younger(input logic flag, input logic [ROB_W-1:0] idx);
    return (flush_robidx_flag ^ flag) ^ (flush_robidx < idx);
  endfunction

  logic [XLEN-1:0] in_addr, in_base;
  logic [5:0]      in_sh;
  logic            in_mis, kill_in, alloc_fire;

  assign in_addr = in_src1 + in_imm;
  assign in_sh   = {in_addr[2:0], 3'b000};

  always_comb begin
    in_base = '1;
    if (in_ls_size[0])      in_base = {{(XLEN-8){1'b0}}, 8'hFF};
    else if (in_ls_size[1]) in_base = {{(XLEN-16){1'b0}}, 16'hFFFF};
    else if (in_ls_size[2]) in_base = {{(XLEN-32){1'b0}}, 32'hFFFF_FFFF};
  end

`ifdef LSU_MISALIGN_CHECK_EN
  assign in_mis = (in_ls_size[1] & in_addr[0]) | (in_ls_size[2] & (|in_addr[1:0])) |
                  (in_ls_size[3] & (|in_addr[2:0]));
`else
  assign in_mis = 1'b0;
`endif

  assign in_ready   = !((alloc_ptr[IW-1:0] == retire_ptr[IW-1:0]) && (alloc_ptr[IW] != retire_ptr[IW]));
  assign busy       = (alloc_ptr != retire_ptr);
  assign kill_in    = flush_valid & younger(in_robidx_flag, in_robidx);
  assign alloc_fire = in_valid & in_ready & (in_is_load | in_is_store) & ~kill_in;

  logic [IW-1:0] alloc_idx, iss_idx, ret_idx;
  logic          iss_pend, iss_drop, issue_adv;
  assign alloc_idx = alloc_ptr[IW-1:0];
  assign iss_idx   = issue_ptr[IW-1:0];
  assign ret_idx   = retire_ptr[IW-1:0];

  // Request fields come straight from queue storage, so they stay put while stalled.
  assign iss_pend        = (issue_ptr != alloc_ptr) & e_valid[iss_idx];
  assign iss_drop        = iss_pend & (e_killed[iss_idx] | e_mis[iss_idx]);
  assign tbus_req_valid  = iss_pend & ~iss_drop;
  assign tbus_req_addr   = e_addr[iss_idx];
  assign tbus_req_wdata  = e_wdata[iss_idx];
  assign tbus_req_wmask  = e_wmask[iss_idx];
  assign tbus_req_optype = {1'b0, ~e_load[iss_idx]};
  assign issue_adv       = iss_drop | (tbus_req_valid & tbus_req_ready);

  logic ret_pend, resp_done, ret_skip, retire_fire, out_kill;
  assign ret_pend    = busy & e_valid[ret_idx];
  assign resp_done   = ret_pend & e_issued[ret_idx] & tbus_resp_valid;
  assign ret_skip    = ret_pend & ~e_issued[ret_idx] & (e_killed[ret_idx] | e_mis[ret_idx]) &
                       (issue_ptr != retire_ptr);
  assign retire_fire = resp_done | ret_skip;
  assign out_kill    = e_killed[ret_idx] | (flush_valid & younger(e_flag[ret_idx], e_rob[ret_idx]));

  logic [2:0]      ra;
  logic [7:0]      ld_b;
  logic [15:0]     ld_h;
  logic [31:0]     ld_w;
  logic [XLEN-1:0] ld_data;
  assign ra   = e_addr[ret_idx][2:0];
  assign ld_b = tbus_resp_rdata[{ra, 3'b000} +: 8];
  assign ld_h = tbus_resp_rdata[{ra[2:1], 4'b0000} +: 16];
  assign ld_w = tbus_resp_rdata[{ra[2], 5'b00000} +: 32];

  always_comb begin
    ld_data = tbus_resp_rdata;
    if (e_size[ret_idx][0])
      ld_data = {{(XLEN-8){ld_b[7] & ~e_uns[ret_idx]}}, ld_b};
    else if (e_size[ret_idx][1])
      ld_data = {{(XLEN-16){ld_h[15] & ~e_uns[ret_idx]}}, ld_h};
    else if (e_size[ret_idx][2])
      ld_data = {{(XLEN-32){ld_w[31] & ~e_uns[ret_idx]}}, ld_w};
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      alloc_ptr       <= '0;
      issue_ptr       <= '0;
      retire_ptr      <= '0;
      e_valid         <= '0;
      e_killed        <= '0;
      e_issued        <= '0;
      e_load          <= '0;
      e_uns           <= '0;
      e_mis           <= '0;
      e_flag          <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        e_size[i]  <= '0;
        e_addr[i]  <= '0;
        e_wdata[i] <= '0;
        e_wmask[i] <= '0;
        e_prd[i]   <= '0;
        e_rob[i]   <= '0;
      end
      out_valid       <= 1'b0;
      out_need_to_wb  <= 1'b0;
      out_exception   <= 1'b0;
      out_prd         <= '0;
      out_robidx_flag <= 1'b0;
      out_robidx      <= '0;
      out_data        <= '0;
    end else begin
      if (alloc_fire) begin
        e_valid[alloc_idx]  <= 1'b1;
        e_killed[alloc_idx] <= 1'b0;
        e_issued[alloc_idx] <= 1'b0;
        e_load[alloc_idx]   <= in_is_load;
        e_uns[alloc_idx]    <= in_is_unsigned;
        e_mis[alloc_idx]    <= in_mis;
        e_flag[alloc_idx]   <= in_robidx_flag;
        e_size[alloc_idx]   <= in_ls_size;
        e_addr[alloc_idx]   <= in_addr;
        e_wdata[alloc_idx]  <= in_src2 << in_sh;
        e_wmask[alloc_idx]  <= in_base << in_sh;
        e_prd[alloc_idx]    <= in_prd;
        e_rob[alloc_idx]    <= in_robidx;
        alloc_ptr           <= alloc_ptr + PTR_ONE;
      end
      if (flush_valid)
        for (int i = 0; i < DEPTH; i++)
          if (e_valid[i] && younger(e_flag[i], e_rob[i])) e_killed[i] <= 1'b1;
      if (tbus_req_valid && tbus_req_ready) e_issued[iss_idx] <= 1'b1;
      if (issue_adv) issue_ptr <= issue_ptr + PTR_ONE;
      if (retire_fire) begin
        e_valid[ret_idx] <= 1'b0;
        retire_ptr       <= retire_ptr + PTR_ONE;
      end
      // Killed entries (including those killed this very cycle) retire silently.
      out_valid      <= retire_fire & ~out_kill;
      out_need_to_wb <= retire_fire & ~out_kill & e_load[ret_idx] & ~e_mis[ret_idx];
      out_exception  <= retire_fire & ~out_kill & e_mis[ret_idx];
      if (retire_fire) begin
        out_prd         <= e_prd[ret_idx];
        out_robidx_flag <= e_flag[ret_idx];
        out_robidx      <= e_rob[ret_idx];
        out_data        <= (e_load[ret_idx] && !e_mis[ret_idx]) ? ld_data : '0;
      end
    end
  end
endmodule

// File: tb/tb_memblock_mq.sv
// tb/tb_memblock_mq.sv - scoreboard bench for memblock_mq
// Honours LSU_MISALIGN_CHECK_EN to pick the expected misaligned behaviour.
module tb_memblock_mq;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, in_is_load, in_is_store, in_is_unsigned;
  logic [3:0]  in_ls_size;
  logic [63:0] in_src1, in_imm, in_src2;
  logic [5:0]  in_prd, in_robidx;
  logic        in_robidx_flag;
  logic        tbus_req_valid, tbus_req_ready;
  logic [63:0] tbus_req_addr, tbus_req_wdata, tbus_req_wmask;
  logic [1:0]  tbus_req_optype;
  logic        tbus_resp_valid;
  logic [63:0] tbus_resp_rdata;
  logic        flush_valid, flush_robidx_flag;
  logic [5:0]  flush_robidx;
  logic        out_valid, out_need_to_wb, out_exception, out_robidx_flag, busy;
  logic [5:0]  out_prd, out_robidx;
  logic [63:0] out_data;

  memblock_mq #(.XLEN(64), .PREG_W(6), .ROB_W(6), .DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_is_load(in_is_load), .in_is_store(in_is_store),
    .in_is_unsigned(in_is_unsigned), .in_ls_size(in_ls_size), .in_src1(in_src1), .in_imm(in_imm),
    .in_src2(in_src2), .in_prd(in_prd), .in_robidx_flag(in_robidx_flag), .in_robidx(in_robidx),
    .tbus_req_valid(tbus_req_valid), .tbus_req_ready(tbus_req_ready), .tbus_req_addr(tbus_req_addr),
    .tbus_req_wdata(tbus_req_wdata), .tbus_req_wmask(tbus_req_wmask), .tbus_req_optype(tbus_req_optype),
    .tbus_resp_valid(tbus_resp_valid), .tbus_resp_rdata(tbus_resp_rdata),
    .flush_valid(flush_valid), .flush_robidx_flag(flush_robidx_flag), .flush_robidx(flush_robidx),
    .out_valid(out_valid), .out_need_to_wb(out_need_to_wb), .out_exception(out_exception),
    .out_prd(out_prd), .out_robidx_flag(out_robidx_flag), .out_robidx(out_robidx),
    .out_data(out_data), .busy(busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] wmask;
    logic [1:0]  op;
  } req_t;
  typedef struct {
    logic [5:0]  prd;
    logic        fl;
    logic [5:0]  rob;
    logic        need;
    logic        exc;
    logic [63:0] data;
    logic        chk;
  } out_t;

  req_t req_q[$];
  out_t out_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Bus and writeback monitors pop the scoreboard whenever the DUT produces something.
  always @(negedge clock) begin
    if (reset_n) begin
      if (tbus_req_valid && tbus_req_ready) begin
        if (req_q.size() == 0) check("req_unexpected", 64'd1, 64'd0);
        else begin
          req_t r;
          r = req_q.pop_front();
          check("req_addr", tbus_req_addr, r.addr);
          check("req_wdata", tbus_req_wdata, r.wdata);
          check("req_wmask", tbus_req_wmask, r.wmask);
          check("req_optype", {62'd0, tbus_req_optype}, {62'd0, r.op});
        end
      end
      if (out_valid) begin
        if (out_q.size() == 0) check("out_unexpected", 64'd1, 64'd0);
        else begin
          out_t o;
          o = out_q.pop_front();
          check("out_prd", {58'd0, out_prd}, {58'd0, o.prd});
          check("out_flag", {63'd0, out_robidx_flag}, {63'd0, o.fl});
          check("out_robidx", {58'd0, out_robidx}, {58'd0, o.rob});
          check("out_need_to_wb", {63'd0, out_need_to_wb}, {63'd0, o.need});
          check("out_exception", {63'd0, out_exception}, {63'd0, o.exc});
          if (o.chk) check("out_data", out_data, o.data);
        end
      end
    end
  end

  task automatic issue_op(input bit ld, input bit uns, input logic [3:0] sz,
                          input logic [63:0] s1, input logic [63:0] imm, input logic [63:0] s2,
                          input logic [5:0] prd, input logic fl, input logic [5:0] rob,
                          input bit exp_req, input bit exp_out, input logic [63:0] exp_data);
    logic [63:0] a, base;
    int sh;
    bit mis;
    req_t r;
    out_t o;
    for (int k = 0; k < 50 && !in_ready; k++) tick();
    if (!in_ready) check("in_ready_wait", 64'd0, 64'd1);
    a    = s1 + imm;
    sh   = int'(a[2:0]) * 8;
    base = sz[0] ? 64'hFF : sz[1] ? 64'hFFFF : sz[2] ? 64'hFFFF_FFFF : 64'hFFFF_FFFF_FFFF_FFFF;
`ifdef LSU_MISALIGN_CHECK_EN
    mis = (sz[1] && a[0]) || (sz[2] && a[1:0] != 2'b00) || (sz[3] && a[2:0] != 3'b000);
`else
    mis = 1'b0;
`endif
    if (exp_req) begin
      r.addr = a; r.wdata = s2 << sh; r.wmask = base << sh; r.op = ld ? 2'd0 : 2'd1;
      req_q.push_back(r);
    end
    if (exp_out) begin
      o.prd = prd; o.fl = fl; o.rob = rob; o.need = ld && !mis; o.exc = mis;
      o.data = exp_data; o.chk = ld && !mis;
      out_q.push_back(o);
    end
    in_valid = 1; in_is_load = ld; in_is_store = !ld; in_is_unsigned = uns; in_ls_size = sz;
    in_src1 = s1; in_imm = imm; in_src2 = s2; in_prd = prd; in_robidx_flag = fl; in_robidx = rob;
    tick();
    in_valid = 0;
  endtask

  task automatic respond(input logic [63:0] d);
    tbus_resp_valid = 1; tbus_resp_rdata = d;
    tick();
    tbus_resp_valid = 0;
  endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 40 && (busy || req_q.size() != 0 || out_q.size() != 0); k++) tick();
    check({tag, "_busy"}, {63'd0, busy}, 64'd0);
    check({tag, "_req_left"}, 64'(req_q.size()), 64'd0);
    check({tag, "_out_left"}, 64'(out_q.size()), 64'd0);
  endtask

  initial begin
    reset_n = 0; in_valid = 0; in_is_load = 0; in_is_store = 0; in_is_unsigned = 0; in_ls_size = 0;
    in_src1 = 0; in_imm = 0; in_src2 = 0; in_prd = 0; in_robidx_flag = 0; in_robidx = 0;
    tbus_req_ready = 1; tbus_resp_valid = 0; tbus_resp_rdata = 0;
    flush_valid = 0; flush_robidx_flag = 0; flush_robidx = 0;
    tick(); tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_req_valid", {63'd0, tbus_req_valid}, 64'd0);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    reset_n = 1;
    tick();

    // 1b unsigned and signed loads at 0x1003
    issue_op(1, 1, 4'b0001, 64'h1000, 64'd3, 64'd0, 6'd5, 1'b0, 6'd1, 1, 1, 64'h80);
    check("req_latency", {63'd0, tbus_req_valid}, 64'd1);
    tick();
    respond(64'h0000_0000_80FF_0000);
    check("out_latency", {63'd0, out_valid}, 64'd1);
    tick();
    check("out_pulse", {63'd0, out_valid}, 64'd0);
    issue_op(1, 0, 4'b0001, 64'h1000, 64'd3, 64'd0, 6'd6, 1'b0, 6'd2, 1, 1, 64'hFFFF_FFFF_FFFF_FF80);
    tick();
    respond(64'h0000_0000_80FF_0000);
    drain("ld1b");

    // 1h store at 0x2006
    issue_op(0, 0, 4'b0010, 64'h2000, 64'd6, 64'hABCD, 6'd7, 1'b0, 6'd3, 1, 1, 64'd0);
    tick();
    respond(64'd0);
    drain("st1h");

    // DEPTH outstanding 2w loads, responses withheld
    for (int i = 0; i < 4; i++)
      issue_op(1, 0, 4'b1000, 64'h100 + 64'(i * 8), 64'd0, 64'd0, 6'(20 + i), 1'b0, 6'(10 + i),
               1, 1, 64'hA5A5_0000_0000_0000 + 64'(i));
    tick();
    check("full_in_ready", {63'd0, in_ready}, 64'd0);
    check("full_issued", 64'(req_q.size()), 64'd0);
    check("full_busy", {63'd0, busy}, 64'd1);
    for (int i = 0; i < 4; i++) respond(64'hA5A5_0000_0000_0000 + 64'(i));
    drain("depth");

    // flush kills robidx 4 (issued) and 5 (not issued)
    for (int i = 0; i < 3; i++)
      issue_op(1, 0, 4'b1000, 64'h200 + 64'(i * 8), 64'd0, 64'd0, 6'(30 + i), 1'b0, 6'(2 + i),
               1, i < 2, 64'h5A00 + 64'(i));
    tick();
    tbus_req_ready = 0;
    issue_op(1, 0, 4'b1000, 64'h218, 64'd0, 64'd0, 6'd33, 1'b0, 6'd5, 0, 0, 64'd0);
    flush_valid = 1; flush_robidx_flag = 0; flush_robidx = 6'd3;
    tick();
    flush_valid = 0;
    tbus_req_ready = 1;
    tick(); tick();
    for (int i = 0; i < 3; i++) respond(64'h5A00 + 64'(i));
    drain("flush");

    // incoming instruction younger than a concurrent flush is dropped
    flush_valid = 1; flush_robidx = 6'd8;
    issue_op(1, 0, 4'b1000, 64'h300, 64'd0, 64'd0, 6'd9, 1'b0, 6'd9, 0, 0, 64'd0);
    flush_valid = 0;
    check("kill_in_busy", {63'd0, busy}, 64'd0);

    // request held stable while ready is low
    tbus_req_ready = 0;
    issue_op(0, 0, 4'b0100, 64'h3000_0000, 64'd4, 64'h1122_3344, 6'd1, 1'b0, 6'd12, 1, 1, 64'd0);
    for (int i = 0; i < 5; i++) begin
      check("hold_valid", {63'd0, tbus_req_valid}, 64'd1);
      check("hold_addr", tbus_req_addr, 64'h3000_0004);
      check("hold_wdata", tbus_req_wdata, 64'h1122_3344_0000_0000);
      check("hold_wmask", tbus_req_wmask, 64'hFFFF_FFFF_0000_0000);
      tick();
    end
    tbus_req_ready = 1;
    tick();
    check("hold_single", {63'd0, tbus_req_valid}, 64'd0);
    respond(64'd0);
    drain("hold");

    // 1w load at 0x1002
`ifdef LSU_MISALIGN_CHECK_EN
    issue_op(1, 1, 4'b0100, 64'h1000, 64'd2, 64'd0, 6'd14, 1'b1, 6'd20, 0, 1, 64'd0);
    tick(); tick();
`else
    issue_op(1, 1, 4'b0100, 64'h1000, 64'd2, 64'd0, 6'd14, 1'b1, 6'd20, 1, 1, 64'h9ABC_DEF0);
    tick();
    respond(64'h1234_5678_9ABC_DEF0);
`endif
    drain("misalign");

    // reset with a request pending, then a stray response
    tbus_req_ready = 0;
    issue_op(1, 0, 4'b1000, 64'h400, 64'd0, 64'd0, 6'd2, 1'b0, 6'd30, 0, 0, 64'd0);
    reset_n = 0;
    tick();
    reset_n = 1;
    check("midrst_busy", {63'd0, busy}, 64'd0);
    check("midrst_req_valid", {63'd0, tbus_req_valid}, 64'd0);
    tbus_req_ready = 1;
    respond(64'hDEAD);
    check("stray_out_valid", {63'd0, out_valid}, 64'd0);
    check("stray_busy", {63'd0, busy}, 64'd0);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/memblock_mq.md
# memblock_mq

Parametrised multi-outstanding load/store unit for the backend memory stage. It accepts one issued load or store per cycle into a DEPTH-entry in-order request queue and drives requests onto the trinity bus (tbus) from that queue. It retires responses in program order to writeback, honouring redirect flushes by ROB age. It replaces the single-outstanding blocking memory stage, so new instructions are no longer stalled while a bus operation is in flight.

## Interface
- XLEN, 64, data/address width
- PREG_W, 6, physical register index width
- ROB_W, 6, ROB index width (flag carried separately)
- DEPTH, 4, queue entries; power of two, 2..16
- clock  in  1  sole clock
- reset_n  in  1  reset, synchronous, active-low
- in_valid / in_ready  in/out  1  issue handshake; in_ready = (count < DEPTH)
- in_is_load, in_is_store, in_is_unsigned  in  1  op decode
- in_ls_size  in  4  one-hot {2w,1w,1h,1b} = bits {3,2,1,0}
- in_src1, in_imm, in_src2  in  XLEN  base, offset, store data
- in_prd  in  PREG_W ; in_robidx_flag  in  1 ; in_robidx  in  ROB_W
- tbus_req_valid / tbus_req_ready  out/in  1  bus request handshake
- tbus_req_addr, tbus_req_wdata, tbus_req_wmask  out  XLEN  address, shifted data, bit mask
- tbus_req_optype  out  2  0 = read, 1 = write
- tbus_resp_valid  in  1  operation done, in request order ; tbus_resp_rdata  in  XLEN
- flush_valid, flush_robidx_flag  in  1 ; flush_robidx  in  ROB_W
- out_valid, out_need_to_wb, out_exception  out  1
- out_prd  out  PREG_W ; out_robidx_flag  out  1 ; out_robidx  out  ROB_W ; out_data  out  XLEN
- busy  out  1  queue non-empty

## Operation
- Entry fields: valid, killed, issued, is_load, unsigned, size, addr (src1+imm, XLEN wrap), wdata, wmask, prd, rob flag/idx, misaligned.
- Three pointers, each log2(DEPTH)+1 bits (wrap bit): alloc, issue, retire. Full when alloc and retire differ only in the wrap bit; empty when they are equal.
- Alloc: in_valid & in_ready & (in_is_load | in_is_store) & ~kill_in writes entry[alloc] and increments alloc.
- Issue: entry[issue] valid, not killed, not misaligned and issue != alloc drives the tbus request. Mask is the size-based base mask << addr[2:0]*8 (all-ones for 2w). Wdata = src2 << addr[2:0]*8.
- On the fire, the entry is marked issued and issue increments. A killed or misaligned entry at issue is skipped (issue++) without a bus request.
- Request fields are held stable while valid & ~ready.
- Response: tbus_resp_valid completes the oldest issued, un-retired entry, which is always entry[retire].
- Load data: shift by addr[2:0]*8 / addr[2:1]*16 / addr[2]*32, then zero- or sign-extend per size and unsigned. A 2w load passes rdata unchanged.
- Retire: entry[retire] retires when its response arrives, or when it is killed/misaligned with issue past it. Retire then increments.
- Output is a registered pulse, only for non-killed entries: out_need_to_wb = is_load & ~exception.
- Age compare: younger(e) = (flush_flag ^ e.flag) ^ (flush_robidx < e.robidx). On flush_valid, every valid entry with younger(e) is set killed.
- kill_in = the same compare applied to the incoming instruction. A killed incoming instruction is consumed but not allocated.
- A killed entry that has already issued still waits for its response, but produces no output.
- Address range 0x30000000..0x40700000 is issued normally; MMIO ordering is guaranteed by the in-order queue.

## Timing
- Reset (reset_n low at a clock edge): pointers 0, all entries invalid, all outputs 0, in_ready 1, busy 0. A reset taken mid-operation abandons outstanding requests, and any later tbus_resp_valid while empty is ignored.
- Accept at cycle N: tbus_req_valid at the earliest in N+1. Response at cycle M: out_valid at M+1.
- Throughput is one alloc, one issue and one retire per cycle, all concurrently.
- When full, in_ready is 0 even if a retire occurs in the same cycle (no bypass).
- Flush and response to the same entry in the same cycle: the entry retires with no output.
- Flush and alloc in the same cycle: the new entry is evaluated with kill_in.
- Back-to-back requests: the bus may accept on consecutive cycles, up to DEPTH outstanding.

## Configuration
- LSU_MISALIGN_CHECK_EN defined: an access is misaligned if it is 1h with addr[0] set, 1w with addr[1:0] nonzero, or 2w with addr[2:0] nonzero.
- A misaligned entry is never sent on the bus. It retires in order with out_valid = 1, out_exception = 1, out_need_to_wb = 0.
- LSU_MISALIGN_CHECK_EN undefined: the misaligned field is tied 0, out_exception is constant 0, and misaligned addresses issue with the plain shift.

## Test plan
- Load 1b unsigned, src1 = 0x1000, imm = 3, rdata = 0x00000000_80FF0000 -> req addr 0x1003; out_data 0x80 (signed variant gives 0xFFFFFFFFFFFFFF80); out_valid one cycle after resp.
- Store 1h, addr 0x2006, src2 = 0xABCD -> wmask 0xFFFF000000000000, wdata 0xABCD000000000000, optype 1; out_valid with need_to_wb 0.
- DEPTH = 4 outstanding loads, tbus_req_ready 1, responses withheld -> 4 requests issued, in_ready 0 on the 5th; releasing responses retires all 4 in order.
- Four queued entries with robidx 2,3,4,5 (flag 0), flush robidx 3 -> robidx 4 and 5 are killed; the already-issued one emits no out_valid, the unissued one produces no request; robidx 2 and 3 retire normally.
- tbus_req_ready held 0 for 5 cycles -> request fields stable throughout; single fire on release.
- With LSU_MISALIGN_CHECK_EN, 1w load at 0x1002 -> no bus request, out_exception 1; without the macro -> request issued, out_exception 0.
